// File: rtl/fetch_uni.sv
// fetch_uni: LEGv8 instruction fetch stage (PC, variable-latency imem handshake, instruction register, next-PC)
// Ports:
//   iCLK, iRST_n                    clock, async active-low reset
//   oIMemReq, oIMemAddr             one-cycle fetch strobe and fetch address (= PC)
//   iIMemRdata, iIMemValid, iIMemErr  memory response
//   iBranch, iZero, iStall          decoder branch, ALU zero, datapath hold (used in EXEC only)
//   oInstr, oOpcode, oPC            instruction register, its opcode field, its PC
//   oInstrValid, oFault             instruction executing, sticky fault
module fetch_uni #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000,
  parameter int TIMEOUT = 16
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  output logic        oIMemReq,
  output logic [63:0] oIMemAddr,
  input  logic [31:0] iIMemRdata,
  input  logic        iIMemValid,
  input  logic        iIMemErr,
  input  logic        iBranch,
  input  logic        iZero,
  input  logic        iStall,
  output logic [31:0] oInstr,
  output logic [10:0] oOpcode,
  output logic [63:0] oPC,
  output logic        oInstrValid,
  output logic        oFault
);
  typedef enum logic [2:0] {RESET, FETCH, WAIT, EXEC, HALT} stateT;
  stateT state, stateNext;
  logic [63:0] pc, pcNext, offset;
  logic [31:0] instr, instrNext;
  logic [7:0] cnt, cntNext;
  logic respond, isB, takeCb;
  assign respond = (state == FETCH || state == WAIT) && iIMemValid;
  assign isB = instr[31:26] == 6'b000101;
  // CBZ takes the branch on zero, CBNZ (bit 24 set) on non-zero
  assign takeCb = iBranch & (iZero ^ instr[24]);
  assign offset = isB ? {{36{instr[25]}}, instr[25:0], 2'b00}
                : takeCb ? {{43{instr[23]}}, instr[23:5], 2'b00} : 64'd4;
  always_comb begin
    stateNext = state;
    pcNext = pc;
    instrNext = instr;
    cntNext = cnt;
    case (state)
      RESET: stateNext = FETCH;
      FETCH, WAIT: begin
        if (respond) begin
          // an errored response halts without disturbing the instruction register
          stateNext = iIMemErr ? HALT : EXEC;
          instrNext = iIMemErr ? instr : iIMemRdata;
        end else if (state == FETCH) begin
          stateNext = WAIT;
          cntNext = 8'd0;
        end else begin
          cntNext = cnt + 8'd1;
          stateNext = (cnt + 8'd1 == 8'(TIMEOUT)) ? HALT : WAIT;
        end
      end
      EXEC: begin
        if (!iStall) begin
          pcNext = pc + offset;
          stateNext = FETCH;
        end
      end
      default: stateNext = state;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= RESET;
      pc <= RESET_PC;
      instr <= 32'h0;
      cnt <= 8'd0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      instr <= instrNext;
      cnt <= cntNext;
    end
  end
  assign oIMemReq = state == FETCH;
  assign oIMemAddr = pc;
  assign oPC = pc;
  assign oInstr = instr;
  assign oOpcode = instr[31:21];
  assign oInstrValid = state == EXEC;
  assign oFault = state == HALT;
endmodule

// File: doc/fetch_uni.md
# fetch_uni

Instruction fetch stage for the single-cycle LEGv8 core. It owns the program counter, fetches each 32-bit instruction from instruction memory over a variable-latency request/valid handshake, and holds the word in an instruction register. While the instruction executes, it drives `oOpcode` (bits 31:21) into the control decoder. It computes the next PC from the decoder's branch signal, the ALU zero flag and the branch immediates held in the instruction register.

## Interface

- `RESET_PC`, default 64'h0000_0000_0040_0000: PC value loaded on reset; bits [1:0] must be 0.
- `TIMEOUT`, default 16: maximum cycles spent waiting for `iIMemValid` before a fault is raised; range 1..255.

- `iCLK`  in  1  clock; all state changes on the rising edge.
- `iRST_n`  in  1  asynchronous, active-low reset.
- `oIMemReq`  out  1  one-cycle fetch request strobe.
- `oIMemAddr`  out  64  fetch address; equals the PC.
- `iIMemRdata`  in  32  instruction word; sampled when `iIMemValid`=1.
- `iIMemValid`  in  1  read data valid.
- `iIMemErr`  in  1  memory error; sampled when `iIMemValid`=1.
- `iBranch`  in  1  conditional-branch indication from the control decoder.
- `iZero`  in  1  ALU zero flag.
- `iStall`  in  1  datapath hold; keeps the current instruction in execute.
- `oInstr`  out  32  instruction register.
- `oOpcode`  out  11  `oInstr[31:21]`.
- `oPC`  out  64  PC of the instruction in `oInstr`.
- `oInstrValid`  out  1  `oInstr` is executing this cycle.
- `oFault`  out  1  sticky fault flag.

## Operation

- The FSM has five states: RESET, FETCH, WAIT, EXEC and HALT.
  - RESET: entered asynchronously while `iRST_n`=0. On the first clock after release it moves to FETCH.
  - FETCH: `oIMemReq`=1 for exactly one cycle. If `iIMemValid`=1 in the same cycle (zero-wait memory), the word is captured and the FSM moves to EXEC. Otherwise it moves to WAIT and clears the timeout counter.
  - WAIT: `oIMemReq`=0. On `iIMemValid`=1 the word is captured and the FSM moves to EXEC. Otherwise the counter increments. When the counter reaches `TIMEOUT`, the FSM moves to HALT.
  - EXEC: `oInstrValid`=1. If `iStall`=1 the FSM stays in EXEC and the PC holds. If `iStall`=0, the PC is loaded with next-PC and the FSM moves to FETCH.
  - HALT: `oFault`=1. No further requests are issued. Only reset leaves HALT.
- `iIMemErr`=1 together with `iIMemValid`=1 moves the FSM to HALT. `oInstr` is not updated in that case.
- Next-PC is selected in EXEC with the following priority:
  - Unconditional B: `oInstr[31:26]`=6'b000101. Next-PC = PC + (sign-extended `oInstr[25:0]` << 2).
  - Conditional branch: `iBranch` & (`iZero` ^ `oInstr[24]`). CBZ has bit 24 = 0; CBNZ has bit 24 = 1. Next-PC = PC + (sign-extended `oInstr[23:5]` << 2).
  - Otherwise: next-PC = PC + 4.
- All PC arithmetic is 64-bit modulo 2^64. Wrap-around is silent.
- `iBranch`, `iZero` and `iStall` are ignored outside EXEC.
- `iIMemValid` is ignored in RESET, EXEC and HALT; a stray valid is dropped.
- Reset values:
  - PC = `RESET_PC`, so `oPC`=`oIMemAddr`=`RESET_PC`.
  - `oInstr`=32'h0, so `oOpcode`=11'h0.
  - `oIMemReq`=0, `oInstrValid`=0, `oFault`=0.
  - Timeout counter = 0.
- Reset asserted mid-operation (any state, including WAIT with a request outstanding) returns the block to RESET immediately. A late `iIMemValid` that arrives in RESET is ignored.

## Timing

- Fetch-to-execute latency is N+1 cycles when memory responds N cycles after the FETCH cycle (N ≥ 0).
- Zero-wait throughput is one instruction per two cycles: FETCH, EXEC, FETCH, and so on.
- `oInstr`, `oOpcode` and `oPC` are registered. They are stable throughout EXEC and remain valid until the next capture.
- The next-PC path is combinational from `iBranch` and `iZero` (through the decoder and ALU) to the PC register. It is resolved in the EXEC cycle only.
- `oIMemAddr` equals the PC register and changes only on the cycle after EXEC with `iStall`=0.
- The timeout counter is 8 bits wide. With no response, HALT is entered exactly `TIMEOUT` cycles after entering WAIT.

## Test plan

- Reset, then zero-wait memory returning ADD (32'h8B020020) at 0x400000: `oOpcode`=11'h458. `oInstrValid` is high on the second cycle after reset release. The next `oIMemAddr` is 0x400004.
- Three-cycle-latency memory: `oIMemReq` pulses once, `oInstrValid` rises 4 cycles after the FETCH cycle, and `oPC` holds during the wait.
- CBZ with imm19=-2 at 0x400010 and `iBranch`=1, `iZero`=1: next PC is 0x400008. The same instruction with `iZero`=0 gives 0x400014. CBNZ (bit 24 = 1) with `iZero`=0 gives 0x400008.
- B with imm26=+3 at 0xFFFF_FFFF_FFFF_FFFC: next PC wraps to 0x8. `iStall`=1 for 2 cycles holds EXEC and the PC unchanged.
- No `iIMemValid` for 16 cycles in WAIT: HALT with `oFault`=1 and no further `oIMemReq`. `iIMemErr` with valid also gives HALT, with `oInstr` unchanged.
- `iRST_n` asserted during WAIT: outputs return to their reset values immediately. A valid that arrives one cycle after release is ignored, and a new FETCH is issued at `RESET_PC`.
